// File: rtl/prefetch_queue_if.sv
// rtl/prefetch_queue_if.sv - instruction bus, fetch-buffer handshake and redirect bundle for prefetch_queue
interface prefetch_queue_if #(
  parameter int DEPTH = 4
);
  logic                     redirect_en;
  logic [31:0]              redirect_pc;
  logic                     imem_ren;
  logic [31:0]              imem_addr;
  logic                     imem_busy;
  logic [31:0]              imem_rdata;
  logic                     fb_valid;
  logic [31:0]              fb_inst;
  logic [31:0]              fb_pc;
  logic                     fb_ready;
  logic [$clog2(DEPTH):0]   q_count;

  modport master (
    input  redirect_en, redirect_pc, imem_busy, imem_rdata, fb_ready,
    output imem_ren, imem_addr, fb_valid, fb_inst, fb_pc, q_count
  );

  modport slave (
    output redirect_en, redirect_pc, imem_busy, imem_rdata, fb_ready,
    input  imem_ren, imem_addr, fb_valid, fb_inst, fb_pc, q_count
  );
endinterface

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - sequential instruction prefetcher with PC-tagged queue and redirect flush
// Optional same-cycle bus-to-output bypass is enabled by defining PREFETCH_BYPASS_EN.
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h200
) (
  input  logic             CLK,
  input  logic             RST,
  prefetch_queue_if.master bus
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t        state_q, state_d;
  logic          started;
  logic [31:0]   fetch_pc, target_pc, redirect_tgt;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic          ren, complete, abandon, bypass, push, pop;

  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    abandon = 1'b0;
    case (state_q)
      FETCH: begin
        // count can only rise on a completion, so a raised ren stays raised until it completes
        ren     = started && (count != FULL);
        abandon = bus.redirect_en && ren && bus.imem_busy;
        if (abandon) state_d = DISCARD;
      end
      DISCARD: begin
        ren = 1'b1;
        if (!bus.imem_busy) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    complete = ren && !bus.imem_busy;
`ifdef PREFETCH_BYPASS_EN
    bypass = (count == '0) && (state_q == FETCH) && complete && !bus.redirect_en;
`else
    bypass = 1'b0;
`endif
    push = complete && (state_q == FETCH) && !bus.redirect_en && !(bypass && bus.fb_ready);
    pop  = (count != '0) && bus.fb_ready && !bus.redirect_en;
  end

  assign bus.imem_ren  = ren;
  assign bus.imem_addr = fetch_pc;
  assign bus.q_count   = count;

`ifdef PREFETCH_BYPASS_EN
  assign bus.fb_valid = (count != '0) || bypass;
  assign bus.fb_inst  = bypass ? bus.imem_rdata : inst_mem[head];
  assign bus.fb_pc    = bypass ? fetch_pc       : pc_mem[head];
`else
  assign bus.fb_valid = (count != '0);
  assign bus.fb_inst  = inst_mem[head];
  assign bus.fb_pc    = pc_mem[head];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      started   <= 1'b0;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      state_q <= state_d;
      started <= 1'b1;
      if (bus.redirect_en) target_pc <= redirect_tgt;
      // while discarding, fetch_pc keeps the abandoned address on the bus
      if (state_q == DISCARD) begin
        if (complete) fetch_pc <= bus.redirect_en ? redirect_tgt : target_pc;
      end else if (bus.redirect_en) begin
        if (!abandon) fetch_pc <= redirect_tgt;
      end else if (complete) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (bus.redirect_en) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      inst_mem[tail] <= bus.imem_rdata;
      pc_mem[tail]   <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - randomized self-checking bench for prefetch_queue against a queue model
module tb_prefetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  prefetch_queue_if #(.DEPTH(DEPTH)) bus ();

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h200)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: fetched words as {pc, inst}, next sequential PC, and a pending drop
  logic [63:0] mq[$];
  logic [31:0] next_pc   = 32'h200;
  logic [31:0] drop_addr = 32'h0;
  bit          drop      = 1'b0;
  bit          started   = 1'b0;

  function automatic bit exp_ren();
    return started && (drop || mq.size() < DEPTH);
  endfunction

  function automatic logic [31:0] exp_addr();
    return drop ? drop_addr : next_pc;
  endfunction

  function automatic bit byp();
`ifdef PREFETCH_BYPASS_EN
    return mq.size() == 0 && !drop && exp_ren() && !bus.imem_busy && !bus.redirect_en;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return mq.size() != 0 || byp();
  endfunction

  function automatic logic [63:0] exp_front();
    if (byp()) return {next_pc, bus.imem_rdata};
    return mq[0];
  endfunction

  task automatic drive(input bit busy, input bit rdy, input bit redir, input logic [31:0] rpc);
    bus.imem_busy   = busy;
    bus.imem_rdata  = $urandom;
    bus.fb_ready    = rdy;
    bus.redirect_en = redir;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic tick();
    bit comp, b, pend;
    if (rst) begin
      mq.delete();
      next_pc = 32'h200;
      drop    = 1'b0;
      started = 1'b0;
    end else begin
      comp = exp_ren() && !bus.imem_busy;
      pend = exp_ren() && bus.imem_busy;
      b    = byp();
      if (bus.redirect_en) begin
        if (!drop && pend) begin
          drop      = 1'b1;
          drop_addr = next_pc;
        end else if (drop && comp) begin
          drop = 1'b0;
        end
        next_pc = {bus.redirect_pc[31:2], 2'b00};
        mq.delete();
      end else if (drop) begin
        if (comp) drop = 1'b0;
      end else begin
        if (mq.size() > 0 && bus.fb_ready) void'(mq.pop_front());
        if (comp && !(b && bus.fb_ready)) mq.push_back({next_pc, bus.imem_rdata});
        if (comp) next_pc = next_pc + 32'd4;
      end
      started = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.q_count !== 3'd0) begin n_err++; $display("FAIL reset_q_count: got %0d want 0", bus.q_count); end
    n_cmp++; if (bus.fb_valid !== 1'b0) begin n_err++; $display("FAIL reset_fb_valid: got %b want 0", bus.fb_valid); end
    n_cmp++; if (bus.imem_ren !== 1'b0) begin n_err++; $display("FAIL reset_ren: got %b want 0", bus.imem_ren); end
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h200) begin
      n_err++; $display("FAIL reset_first_req: got ren=%b addr=%h want ren=1 addr=00000200", bus.imem_ren, bus.imem_addr);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [63:0] f;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0);
      if (i >= 1) begin
        n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h200 + 32'(4 * (i - 1))) begin
          n_err++; $display("FAIL stream_addr: got ren=%b addr=%h want ren=1 addr=%h", bus.imem_ren, bus.imem_addr, 32'h200 + 32'(4 * (i - 1)));
        end
      end
      n_cmp++; if (bus.fb_valid !== exp_valid()) begin
        n_err++; $display("FAIL stream_valid: got %b want %b", bus.fb_valid, exp_valid());
      end
      if (exp_valid()) begin
        f = exp_front();
        n_cmp++; if ({bus.fb_pc, bus.fb_inst} !== f) begin
          n_err++; $display("FAIL stream_word: got pc=%h inst=%h want pc=%h inst=%h", bus.fb_pc, bus.fb_inst, f[63:32], f[31:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.q_count !== 3'd4) begin n_err++; $display("FAIL full_q_count: got %0d want 4", bus.q_count); end
    n_cmp++; if (bus.imem_ren !== 1'b0) begin n_err++; $display("FAIL full_ren: got %b want 0", bus.imem_ren); end
    n_cmp++; if (bus.fb_pc !== 32'h200) begin n_err++; $display("FAIL full_head_pc: got %h want 00000200", bus.fb_pc); end
    tick();
    drive(1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h210) begin
      n_err++; $display("FAIL full_resume: got ren=%b addr=%h want ren=1 addr=00000210", bus.imem_ren, bus.imem_addr);
    end
    tick();
  endtask

  task automatic test_redirect_discard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 1, 1, 32'h1002);
      else        drive(i == 3 ? 1'b0 : 1'b1, 1, 0, 0);
      n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h208) begin
        n_err++; $display("FAIL discard_hold: cycle %0d got ren=%b addr=%h want ren=1 addr=00000208", i, bus.imem_ren, bus.imem_addr);
      end
      tick();
    end
    drive(1, 1, 0, 0);
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h1000 || bus.fb_valid !== 1'b0) begin
      n_err++; $display("FAIL discard_restart: got ren=%b addr=%h valid=%b want ren=1 addr=00001000 valid=0", bus.imem_ren, bus.imem_addr, bus.fb_valid);
    end
    tick();
    drive(0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.fb_valid !== 1'b1 || bus.fb_pc !== 32'h1000) begin
      n_err++; $display("FAIL discard_first_pc: got valid=%b pc=%h want valid=1 pc=00001000", bus.fb_valid, bus.fb_pc);
    end
    tick();
  endtask

  task automatic test_redirect_pop();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 1, 32'h3000);
    n_cmp++; if (bus.q_count !== 3'd2) begin n_err++; $display("FAIL redir_pop_pre_count: got %0d want 2", bus.q_count); end
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.q_count !== 3'd0 || bus.fb_valid !== 1'b0) begin
      n_err++; $display("FAIL redir_pop_flush: got count=%0d valid=%b want count=0 valid=0", bus.q_count, bus.fb_valid);
    end
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h3000) begin
      n_err++; $display("FAIL redir_pop_addr: got ren=%b addr=%h want ren=1 addr=00003000", bus.imem_ren, bus.imem_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffffc", bus.imem_addr); end
    tick();
    drive(0, 0, 0, 0);
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr1: got %h want 00000000", bus.imem_addr); end
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.q_count !== 3'd2 || bus.fb_pc !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_pc0: got count=%0d pc=%h want count=2 pc=fffffffc", bus.q_count, bus.fb_pc);
    end
    tick();
    drive(1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.fb_valid !== 1'b1 || bus.fb_pc !== 32'h0) begin
      n_err++; $display("FAIL wrap_pc1: got valid=%b pc=%h want valid=1 pc=00000000", bus.fb_valid, bus.fb_pc);
    end
    tick();
  endtask

  task automatic test_reset_discard();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0);
      tick();
    end
    drive(1, 1, 0, 0);
    tick();
    drive(1, 0, 1, 32'h500);
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h210) begin
      n_err++; $display("FAIL rstdisc_hold: got ren=%b addr=%h want ren=1 addr=00000210", bus.imem_ren, bus.imem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.q_count !== 3'd0 || bus.fb_valid !== 1'b0 || bus.imem_ren !== 1'b0) begin
      n_err++; $display("FAIL rstdisc_state: got count=%0d valid=%b ren=%b want 0 0 0", bus.q_count, bus.fb_valid, bus.imem_ren);
    end
    tick();
    drive(1, 0, 0, 0);
    n_cmp++; if (bus.imem_ren !== 1'b1 || bus.imem_addr !== 32'h200) begin
      n_err++; $display("FAIL rstdisc_restart: got ren=%b addr=%h want ren=1 addr=00000200", bus.imem_ren, bus.imem_addr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] f;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
      n_cmp++; if (bus.imem_ren !== exp_ren()) begin
        n_err++; $display("FAIL rand_ren: cycle %0d got %b want %b", i, bus.imem_ren, exp_ren());
      end
      if (exp_ren()) begin
        n_cmp++; if (bus.imem_addr !== exp_addr()) begin
          n_err++; $display("FAIL rand_addr: cycle %0d got %h want %h", i, bus.imem_addr, exp_addr());
        end
      end
      n_cmp++; if (bus.q_count !== 3'(mq.size())) begin
        n_err++; $display("FAIL rand_count: cycle %0d got %0d want %0d", i, bus.q_count, mq.size());
      end
      n_cmp++; if (bus.fb_valid !== exp_valid()) begin
        n_err++; $display("FAIL rand_valid: cycle %0d got %b want %b", i, bus.fb_valid, exp_valid());
      end
      if (exp_valid()) begin
        f = exp_front();
        n_cmp++; if ({bus.fb_pc, bus.fb_inst} !== f) begin
          n_err++; $display("FAIL rand_word: cycle %0d got pc=%h inst=%h want pc=%h inst=%h", i, bus.fb_pc, bus.fb_inst, f[63:32], f[31:0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    drive(1, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_redirect_discard();
    test_redirect_pop();
    test_wrap();
    test_reset_discard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
